pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register, successor to the fixed-field stage registers between pipeline stages. Carries a control bundle and a data bundle with a valid/ready handshake and a 2-entry skid buffer, so backpressure stalls at full throughput. Flush squashes both entries into a bubble. Saturating stall and flush counters serve the hazard and performance logic.

Parameters:
DATA_W, 32*4+15=143, data payload width (operands, PC+4, sign-extended immediate, register fields).
CTRL_W, 10, control payload width (ALUOp plus single-bit control flags).
CLEAR_DATA, 1, 1: flush and bubbles zero the data payload; 0: data holds and only control is zeroed.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
in_valid  in  1  upstream has a payload.
in_ready  out  1  stage can accept; registered, equals NOT skid-entry-valid.
in_ctrl  in  CTRL_W  upstream control bundle.
in_data  in  DATA_W  upstream data bundle.
flush  in  1  synchronous squash from the hazard unit.
out_valid  out  1  main entry valid.
out_ready  in  1  downstream accepts.
out_ctrl  out  CTRL_W  main entry control; forced 0 when out_valid=0.
out_data  out  DATA_W  main entry data.
stall_cnt  out  CNT_W  cycles with in_valid=1 and in_ready=0.
flush_cnt  out  CNT_W  cycles with flush=1.
clr_cnt  in  1  synchronous clear of both counters.

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-transfer): both entries invalid, out_valid=0, out_ctrl=0, out_data=0, skid contents 0, in_ready=1, stall_cnt=0, flush_cnt=0. Outputs take these values immediately, without waiting for a clock edge.
- Handshake signals: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States:
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - FULL: both entries valid.
- EMPTY:
  - in_fire: main <= in, go to ONE.
  - Otherwise stay in EMPTY.
- ONE:
  - in_fire & out_fire: main <= in, stay in ONE.
  - in_fire only: skid <= in, go to FULL.
  - out_fire only: go to EMPTY.
  - Neither: hold.
- FULL: in_ready=0. On out_fire, main <= skid, skid is cleared, go to ONE. Otherwise hold.
- Latency and throughput: 1 cycle from in_fire to out_valid when the stage is EMPTY or draining. Sustained throughput is 1 payload per cycle with out_ready=1. Strict FIFO order; no payload is dropped or duplicated except on flush.
- Flush has the highest priority after reset. Next state is EMPTY; both entries are invalid; out_ctrl=0; skid ctrl=0. Data is zeroed if CLEAR_DATA=1, otherwise held. in_ready=1 on the next cycle.
  - in_valid in a flush cycle is dropped, never stored.
  - out_fire in a flush cycle still counts as delivered to downstream.
- Bubbles: while out_valid=0, out_ctrl=0 regardless of stored contents. out_data=0 if CLEAR_DATA=1.
- Counters:
  - Increment by 1 per qualifying cycle.
  - Saturate at 2^CNT_W-1 with no wrap.
  - clr_cnt has priority over increment: the counter reads 0 on the next cycle even if the qualifying event occurs in that cycle.
  - stall_cnt and flush_cnt update independently; one cycle may increment both.
- Every output is registered except out_ctrl/out_data gating by out_valid, which comes from a register, so all outputs are glitch-free from flops.

Test Plan:
1. Reset mid-operation:
   - Stimulus: fill to FULL with A=ctrl 0x3FF/data 0xAA.., then pull rst=0 between edges.
   - Required: out_valid=0, out_ctrl=0, out_data=0, in_ready=1, counters=0 immediately; after rst=1, the first new payload appears 1 cycle after in_fire.
2. Streaming:
   - Stimulus: out_ready=1; payloads ctrl=1,2,3,4 on consecutive cycles.
   - Required: out_ctrl=1,2,3,4 each 1 cycle later; in_ready stays 1; stall_cnt=0.
3. Backpressure:
   - Stimulus: out_ready=0; offer A, B, C continuously.
   - Required: A in main, B in skid, in_ready=0 from the cycle after B's accept; stall_cnt counts C's waiting cycles (e.g., 5 wait cycles → 5).
   - Stimulus: raise out_ready.
   - Required: output order A, B, C; no loss.
4. Flush in FULL:
   - Stimulus: stage FULL, flush=1 for one cycle with in_valid=1 carrying D.
   - Required next cycle: out_valid=0, out_ctrl=0, out_data=0 (CLEAR_DATA=1), in_ready=1, flush_cnt=1; D never appears at the output.
5. CLEAR_DATA=0 flush:
   - Stimulus: same as scenario 4.
   - Required: out_ctrl=0, out_valid=0, out_data holds the pre-flush main data.
6. Counter saturation and clear:
   - Stimulus: CNT_W=4; hold in_valid=1, in_ready=0 for 20 cycles.
   - Required: stall_cnt=15 and stays 15.
   - Stimulus: clr_cnt=1 while the stall persists.
   - Required: stall_cnt=0 next cycle, then 1 the cycle after.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with 2-entry skid buffer: 1-cycle latency, full throughput under backpressure.
// in_ready drops only when the skid entry is occupied; flush squashes both entries into a bubble.
module pipe_stage_skid #(
  parameter int DATA_W     = 143,
  parameter int CTRL_W     = 10,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  input  logic              clr_cnt
);

  // Encoding chosen so bit 0 is main-valid and bit 1 is skid-valid, straight from flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state, state_nxt;
  logic              load_main, load_skid, pop_skid;
  logic              in_fire, out_fire;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  assign out_valid = state[0];
  assign in_ready  = ~state[1];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            load_main = 1'b1;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            pop_skid  = 1'b1;
            state_nxt = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
      if (CLEAR_DATA != 0) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      if (load_main) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (pop_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end else if (pop_skid) begin
        skid_ctrl <= '0;
        skid_data <= '0;
      end
    end
  end

  // Bubbles never leak stale control; data is masked only when CLEAR_DATA is set.
  assign out_ctrl = out_valid ? main_ctrl : '0;
  assign out_data = ((CLEAR_DATA != 0) && !out_valid) ? '0 : main_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1))                 flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: default, CLEAR_DATA=0 and CNT_W=4 instances share one stimulus.
module tb_pipe_stage_skid;

  localparam int DW = 143;
  localparam int CW = 10;
  typedef logic [159:0] w_t;

  logic          clk, rst;
  logic          in_valid, out_ready, flush, clr_cnt;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          out_valid, in_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [15:0]   stall_cnt, flush_cnt;

  logic          nc_out_valid, nc_in_ready;
  logic [CW-1:0] nc_out_ctrl;
  logic [DW-1:0] nc_out_data;
  logic [15:0]   nc_stall_cnt, nc_flush_cnt;

  logic          c4_out_valid, c4_in_ready;
  logic [CW-1:0] c4_out_ctrl;
  logic [DW-1:0] c4_out_data;
  logic [3:0]    c4_stall_cnt, c4_flush_cnt;

  int n_chk = 0;
  int n_bad = 0;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .clr_cnt(clr_cnt));

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(0), .CNT_W(16)) u_dut_nc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nc_in_ready), .in_ctrl(in_ctrl),
    .in_data(in_data), .flush(flush), .out_valid(nc_out_valid), .out_ready(out_ready),
    .out_ctrl(nc_out_ctrl), .out_data(nc_out_data), .stall_cnt(nc_stall_cnt),
    .flush_cnt(nc_flush_cnt), .clr_cnt(clr_cnt));

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1), .CNT_W(4)) u_dut_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c4_in_ready), .in_ctrl(in_ctrl),
    .in_data(in_data), .flush(flush), .out_valid(c4_out_valid), .out_ready(out_ready),
    .out_ctrl(c4_out_ctrl), .out_data(c4_out_data), .stall_cnt(c4_stall_cnt),
    .flush_cnt(c4_flush_cnt), .clr_cnt(clr_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dpat(input logic [7:0] b);
    return DW'({18{b}});
  endfunction

  task automatic chk(input string tag, input w_t got, input w_t exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [CW-1:0] c, input logic [7:0] b);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = dpat(b);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
    in_ctrl = '0; in_data = '0;
    #3;
    chk("rst_out_valid", w_t'(out_valid), w_t'(1'b0));
    chk("rst_in_ready",  w_t'(in_ready),  w_t'(1'b1));
    chk("rst_out_ctrl",  w_t'(out_ctrl),  w_t'(0));
    chk("rst_stall_cnt", w_t'(stall_cnt), w_t'(0));
    tick();
    rst = 1'b1;
    tick();

    // streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      offer(CW'(i), 8'(i));
      tick();
      chk("stream_valid", w_t'(out_valid), w_t'(1'b1));
      chk("stream_ctrl",  w_t'(out_ctrl),  w_t'(i));
      chk("stream_ready", w_t'(in_ready),  w_t'(1'b1));
    end
    chk("stream_data", w_t'(out_data), w_t'(dpat(8'h04)));
    in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", w_t'(out_valid), w_t'(1'b0));
    chk("stream_drain_data",  w_t'(out_data),  w_t'(0));
    chk("stream_stall_cnt",   w_t'(stall_cnt), w_t'(0));

    // backpressure: A main, B skid, C waits 5 cycles
    out_ready = 1'b0;
    offer(10'h0A, 8'h0A);
    tick();
    chk("bp_a_ready", w_t'(in_ready), w_t'(1'b1));
    offer(10'h0B, 8'h0B);
    tick();
    chk("bp_b_ready", w_t'(in_ready), w_t'(1'b0));
    offer(10'h0C, 8'h0C);
    repeat (5) tick();
    chk("bp_stall_cnt", w_t'(stall_cnt), w_t'(5));
    chk("bp_hold_a",    w_t'(out_ctrl),  w_t'(10'h0A));
    out_ready = 1'b1;
    tick();
    chk("bp_out_b",     w_t'(out_ctrl),  w_t'(10'h0B));
    chk("bp_b_data",    w_t'(out_data),  w_t'(dpat(8'h0B)));
    chk("bp_ready_back", w_t'(in_ready), w_t'(1'b1));
    tick();
    chk("bp_out_c", w_t'(out_ctrl), w_t'(10'h0C));
    in_valid = 1'b0;
    tick();
    chk("bp_empty", w_t'(out_valid), w_t'(1'b0));

    // flush while FULL, with D offered in the same cycle
    out_ready = 1'b0;
    offer(10'h11, 8'h11);
    tick();
    offer(10'h22, 8'h22);
    tick();
    chk("fl_full", w_t'(in_ready), w_t'(1'b0));
    offer(10'h33, 8'h33);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", w_t'(out_valid), w_t'(1'b0));
    chk("fl_out_ctrl",  w_t'(out_ctrl),  w_t'(0));
    chk("fl_out_data",  w_t'(out_data),  w_t'(0));
    chk("fl_in_ready",  w_t'(in_ready),  w_t'(1'b1));
    chk("fl_flush_cnt", w_t'(flush_cnt), w_t'(1));
    chk("nc_out_valid", w_t'(nc_out_valid), w_t'(1'b0));
    chk("nc_out_ctrl",  w_t'(nc_out_ctrl),  w_t'(0));
    chk("nc_out_data",  w_t'(nc_out_data),  w_t'(dpat(8'h11)));
    out_ready = 1'b1;
    tick();
    chk("fl_no_d", w_t'(out_valid), w_t'(1'b0));

    // asynchronous reset from FULL, asserted between edges
    out_ready = 1'b0;
    offer(10'h3FF, 8'hAA);
    tick();
    tick();
    chk("ar_pre_full", w_t'(in_ready), w_t'(1'b0));
    #2;
    rst = 1'b0;
    #1;
    chk("ar_out_valid", w_t'(out_valid), w_t'(1'b0));
    chk("ar_out_ctrl",  w_t'(out_ctrl),  w_t'(0));
    chk("ar_out_data",  w_t'(out_data),  w_t'(0));
    chk("ar_in_ready",  w_t'(in_ready),  w_t'(1'b1));
    chk("ar_stall_cnt", w_t'(stall_cnt), w_t'(0));
    chk("ar_flush_cnt", w_t'(flush_cnt), w_t'(0));
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("ar_idle", w_t'(out_valid), w_t'(1'b0));
    out_ready = 1'b1;
    offer(10'h55, 8'h55);
    tick();
    chk("ar_first_valid", w_t'(out_valid), w_t'(1'b1));
    chk("ar_first_ctrl",  w_t'(out_ctrl),  w_t'(10'h55));
    in_valid = 1'b0;
    tick();

    // counter saturation on the 4-bit instance, then clear during stall
    out_ready = 1'b0;
    offer(10'h01, 8'h01);
    tick();
    tick();
    repeat (20) tick();
    chk("sat_c4_15",  w_t'(c4_stall_cnt), w_t'(15));
    chk("sat_wide_20", w_t'(stall_cnt),   w_t'(20));
    tick();
    chk("sat_c4_hold", w_t'(c4_stall_cnt), w_t'(15));
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_c4_zero",   w_t'(c4_stall_cnt), w_t'(0));
    chk("clr_wide_zero", w_t'(stall_cnt),    w_t'(0));
    tick();
    chk("clr_c4_one", w_t'(c4_stall_cnt), w_t'(1));
    in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
